ov5640_frame_ctrl: RTL and testbench

- Sequences the camera pixel stream into the VDMA S2MM AXI4-Stream input (frame_in_*).
- Sits between ov5640_capture and the block-design stream port, in the pclk domain.
- Aligns capture to frame boundaries and generates tuser on the first pixel of each frame and tlast on the last pixel of each line.
- Absorbs backpressure in a small FIFO, and drops corrupted frames and flags them instead of pushing misaligned video into DDR.

---
 rtl/ov5640_pkg.sv | 18 +
 rtl/ov5640_pix_fifo.sv | 47 ++++
 rtl/ov5640_frame_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ov5640_frame_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 frame sequencer: FSM states and the
// layout of one stream-buffer entry.
package ov5640_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam int unsigned DATA_W        = 24;
  localparam int unsigned ENTRY_W       = DATA_W + 2;
  localparam int unsigned ENTRY_EOL     = 0;
  localparam int unsigned ENTRY_SOF     = 1;
  localparam int unsigned ENTRY_PIX_LSB = 2;

endpackage

// File: rtl/ov5640_pix_fifo.sv
// Synchronous first-word-fall-through FIFO; writes while full are rejected,
// even when a read happens in the same cycle.
module ov5640_pix_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry one extra wrap bit so full and empty are exact.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr  = wr_en & ~full;
  assign w_rd  = rd_en & ~empty;
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ov5640_frame_ctrl.sv
// Frames the OV5640 pixel stream into AXI4-Stream (tuser = SOF, tlast = EOL),
// buffering backpressure and dropping frames whose timing is corrupted.
module ov5640_frame_ctrl
  import ov5640_pkg::*;
#(
  parameter int unsigned H_ACTIVE          = 640,
  parameter int unsigned V_ACTIVE          = 480,
  parameter int unsigned FIFO_DEPTH        = 16,
  parameter bit          VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        err_clr,
  input  logic        vsync,
  input  logic        pix_valid,
  input  logic        pix_last,
  input  logic [23:0] pix_data,
  output logic [31:0] m_tdata,
  output logic [3:0]  m_tkeep,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_overflow,
  output logic        err_line,
  output logic        err_frame
);

  localparam int unsigned PCNT_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LCNT_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(H_ACTIVE - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(V_ACTIVE - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [PCNT_W-1:0]   w_pcnt_nxt;
  logic [LCNT_W-1:0]   r_lcnt;
  logic [LCNT_W-1:0]   w_lcnt_nxt;
  logic                r_sof_pend;
  logic                w_sof_nxt;
  logic                r_vs_act_d;
  logic                w_vs_act;
  logic                w_fs;
  logic                w_pcnt_last;
  logic                w_lcnt_last;
  logic [15:0]         r_frame_cnt;
  logic                r_err_overflow;
  logic                r_err_line;
  logic                r_err_frame;
  logic                w_set_overflow;
  logic                w_set_line;
  logic                w_set_frame;
  logic                w_frame_done;
  logic                w_fifo_wr;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [ENTRY_W-1:0]  w_fifo_din;
  logic [ENTRY_W-1:0]  w_fifo_dout;

  assign w_vs_act    = ~(vsync ^ VSYNC_ACTIVE_HIGH);
  assign w_fs        = r_vs_act_d & ~w_vs_act;
  assign w_pcnt_last = (r_pcnt == PCNT_LAST);
  assign w_lcnt_last = (r_lcnt == LCNT_LAST);
  assign w_fifo_din  = {pix_data, r_sof_pend, w_pcnt_last};

  always_comb begin
    w_state_nxt    = r_state;
    w_pcnt_nxt     = r_pcnt;
    w_lcnt_nxt     = r_lcnt;
    w_sof_nxt      = r_sof_pend;
    w_fifo_wr      = 1'b0;
    w_set_overflow = 1'b0;
    w_set_line     = 1'b0;
    w_set_frame    = 1'b0;
    w_frame_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_fs) begin
          w_state_nxt = ACTIVE;
          w_pcnt_nxt  = '0;
          w_lcnt_nxt  = '0;
          w_sof_nxt   = 1'b1;
        end
      end
      ACTIVE: begin
        // The offending pixel of a bad line is never queued, so a truncated
        // or overlong line cannot leave a synthesised tlast behind.
        if (pix_valid) begin
          w_set_line     = (pix_last != w_pcnt_last);
          w_set_overflow = w_fifo_full;
        end
        if (w_vs_act) begin
          w_set_frame = 1'b1;
          w_state_nxt = WAIT_VS;
        end else if (pix_valid) begin
          if (w_set_line || w_set_overflow) begin
            w_state_nxt = DROP;
          end else begin
            w_fifo_wr = 1'b1;
            w_sof_nxt = 1'b0;
            if (w_pcnt_last) begin
              w_pcnt_nxt = '0;
              w_lcnt_nxt = r_lcnt + LCNT_W'(1);
              if (w_lcnt_last) begin
                w_frame_done = 1'b1;
                w_state_nxt  = enable ? WAIT_VS : IDLE;
              end
            end else begin
              w_pcnt_nxt = r_pcnt + PCNT_W'(1);
            end
          end
        end
      end
      DROP: begin
        if (w_vs_act) w_state_nxt = WAIT_VS;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_pcnt         <= '0;
      r_lcnt         <= '0;
      r_sof_pend     <= 1'b0;
      r_vs_act_d     <= 1'b0;
      r_frame_cnt    <= '0;
      r_err_overflow <= 1'b0;
      r_err_line     <= 1'b0;
      r_err_frame    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_sof_pend <= w_sof_nxt;
      r_vs_act_d <= w_vs_act;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      // A fresh error event outranks a clear in the same cycle.
      if (w_set_overflow)  r_err_overflow <= 1'b1;
      else if (err_clr)    r_err_overflow <= 1'b0;
      if (w_set_line)      r_err_line     <= 1'b1;
      else if (err_clr)    r_err_line     <= 1'b0;
      if (w_set_frame)     r_err_frame    <= 1'b1;
      else if (err_clr)    r_err_frame    <= 1'b0;
    end
  end

  ov5640_pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pclk),
    .rst_n (reset),
    .wr_en (w_fifo_wr),
    .din   (w_fifo_din),
    .full  (w_fifo_full),
    .rd_en (m_tready),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty)
  );

  assign m_tvalid     = ~w_fifo_empty;
  assign m_tdata      = {8'h00, w_fifo_dout[ENTRY_W-1:ENTRY_PIX_LSB]};
  assign m_tkeep      = 4'b1111;
  assign m_tuser      = w_fifo_dout[ENTRY_SOF] & ~w_fifo_empty;
  assign m_tlast      = w_fifo_dout[ENTRY_EOL] & ~w_fifo_empty;
  assign busy         = (r_state == ACTIVE) || (r_state == DROP);
  assign frame_cnt    = r_frame_cnt;
  assign err_overflow = r_err_overflow;
  assign err_line     = r_err_line;
  assign err_frame    = r_err_frame;

endmodule

// File: tb/tb_ov5640_frame_ctrl.sv
// Directed bench for ov5640_frame_ctrl with a queue-based expected-beat model.
`timescale 1ns/1ps
module tb_ov5640_frame_ctrl;

  localparam int H = 4;
  localparam int V = 3;
  localparam int D = 8;

  logic        pclk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic        vsync = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic [23:0] pix_data = '0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tuser;
  logic        m_tlast;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_overflow;
  logic        err_line;
  logic        err_frame;

  ov5640_frame_ctrl #(
    .H_ACTIVE          (H),
    .V_ACTIVE          (V),
    .FIFO_DEPTH        (D),
    .VSYNC_ACTIVE_HIGH (1'b1)
  ) dut (
    .pclk         (pclk),
    .reset        (reset),
    .enable       (enable),
    .err_clr      (err_clr),
    .vsync        (vsync),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_data     (pix_data),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .err_overflow (err_overflow),
    .err_line     (err_line),
    .err_frame    (err_frame)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    beats    = 0;
  int    n_user   = 0;
  int    n_last   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every handshake beat must match the head of the expected queue; a stalled
  // beat must hold steady until accepted.
  logic        stall_v = 1'b0;
  logic [33:0] stall_beat = '0;
  beat_t       e;
  always @(negedge pclk) begin
    if (!reset) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        check("stall_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_beat", {30'd0, m_tuser, m_tlast} ^ {30'd0, stall_beat[33:32]}, 32'd0);
        check("stall_data", m_tdata, stall_beat[31:0]);
      end
      if (m_tvalid) begin
        check("tkeep", {28'd0, m_tkeep}, 32'hF);
        if (m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_tdata, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_tdata, {8'h00, e.d});
            check("beat_user", {31'd0, m_tuser}, {31'd0, e.u});
            check("beat_last", {31'd0, m_tlast}, {31'd0, e.l});
          end
          beats++;
          if (m_tuser) n_user++;
          if (m_tlast) n_last++;
        end
      end
      stall_v    = m_tvalid & ~m_tready;
      stall_beat = {m_tuser, m_tlast, m_tdata};
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; err_clr = 1'b0; vsync = 1'b0;
    pix_valid = 1'b0; pix_last = 1'b0; m_tready = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    beats = 0; n_user = 0; n_last = 0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_pix(input logic [23:0] d, input logic last, input bit keep,
                          input bit sof, input bit eol);
    beat_t b;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    if (keep) begin
      b.d = d; b.u = sof; b.l = eol;
      exp_q.push_back(b);
    end
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Pixel k of the frame (in sending order) is expected iff k < keep_n.
  task automatic send_frame(input int fid, input int nlines, input int short_line,
                            input int short_len, input int keep_n, input int en_off_line);
    int k;
    int len;
    logic [23:0] d;
    k = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      if (ln == en_off_line) enable = 1'b0;
      len = (ln == short_line) ? short_len : H;
      for (int c = 0; c < len; c++) begin
        d = {fid[7:0], ln[7:0], c[7:0]};
        send_pix(d, c == len - 1, k < keep_n, k == 0, c == H - 1);
        k++;
      end
      idle(1);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
      tick();
      n++;
    end
    check({nm, "_drain_timeout"}, {31'd0, n >= 200}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, normal frame, enable dropped mid-frame
    do_reset();
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tuser", {31'd0, m_tuser}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_errs", {29'd0, err_overflow, err_line, err_frame}, 32'd0);
    enable = 1'b1;
    tick();
    vs_pulse();
    send_frame(1, V, -1, 0, 12, 1);
    drain("t1");
    check("t1_beats", beats, 32'd12);
    check("t1_tuser_cnt", n_user, 32'd1);
    check("t1_tlast_cnt", n_last, 32'd3);
    check("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("t1_errs", {29'd0, err_overflow, err_line, err_frame}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    vs_pulse();
    send_frame(2, V, -1, 0, 0, -1);
    drain("t1b");
    check("t1_disabled_beats", beats, 32'd12);
    check("t1_disabled_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 2: late alignment
    do_reset();
    enable = 1'b1;
    tick();
    send_frame(3, 2, -1, 0, 0, -1);
    check("t2_no_beats", beats, 32'd0);
    check("t2_tvalid", {31'd0, m_tvalid}, 32'd0);
    vs_pulse();
    send_frame(4, V, -1, 0, 12, -1);
    drain("t2");
    check("t2_beats", beats, 32'd12);
    check("t2_tuser_cnt", n_user, 32'd1);
    check("t2_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 3: backpressure overflow
    do_reset();
    enable = 1'b1;
    m_tready = 1'b0;
    tick();
    vs_pulse();
    send_frame(5, V, -1, 0, D, -1);
    check("t3_err_overflow", {31'd0, err_overflow}, 32'd1);
    check("t3_drop_busy", {31'd0, busy}, 32'd1);
    check("t3_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("t3_tvalid_held", {31'd0, m_tvalid}, 32'd1);
    m_tready = 1'b1;
    drain("t3a");
    check("t3_drained", beats, 32'd8);
    vs_pulse();
    send_frame(6, V, -1, 0, 12, -1);
    drain("t3b");
    check("t3_beats", beats, 32'd20);
    check("t3_frame_cnt2", {16'd0, frame_cnt}, 32'd1);
    check("t3_err_sticky", {31'd0, err_overflow}, 32'd1);

    // 4: short line
    do_reset();
    enable = 1'b1;
    tick();
    vs_pulse();
    send_frame(7, V, 1, 3, 6, -1);
    check("t4_err_line", {31'd0, err_line}, 32'd1);
    check("t4_drop_busy", {31'd0, busy}, 32'd1);
    drain("t4a");
    check("t4_beats", beats, 32'd6);
    check("t4_tlast_cnt", n_last, 32'd1);
    check("t4_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    vs_pulse();
    send_frame(8, V, -1, 0, 12, -1);
    drain("t4b");
    check("t4_frame_cnt2", {16'd0, frame_cnt}, 32'd1);
    check("t4_other_errs", {30'd0, err_overflow, err_frame}, 32'd0);

    // 5: early vsync, then error clear
    do_reset();
    enable = 1'b1;
    tick();
    vs_pulse();
    send_frame(9, 1, -1, 0, 4, -1);
    vs_pulse();
    check("t5_err_frame", {31'd0, err_frame}, 32'd1);
    check("t5_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    send_frame(10, V, -1, 0, 12, -1);
    drain("t5");
    check("t5_beats", beats, 32'd16);
    check("t5_tuser_cnt", n_user, 32'd2);
    check("t5_frame_cnt2", {16'd0, frame_cnt}, 32'd1);
    check("t5_err_before_clr", {31'd0, err_frame}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_err_cleared", {31'd0, err_frame}, 32'd0);

    // 6: asynchronous reset mid-frame
    do_reset();
    enable = 1'b1;
    tick();
    vs_pulse();
    send_frame(11, V, -1, 0, 12, -1);
    drain("t6");
    check("t6_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    m_tready = 1'b0;
    vs_pulse();
    send_pix(24'hABCDEF, 1'b0, 1'b1, 1'b1, 1'b0);
    send_pix(24'h123456, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_tvalid_pre", {31'd0, m_tvalid}, 32'd1);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_tvalid_async", {31'd0, m_tvalid}, 32'd0);
    check("t6_frame_cnt_rst", {16'd0, frame_cnt}, 32'd0);
    check("t6_busy_rst", {31'd0, busy}, 32'd0);
    exp_q.delete();
    enable = 1'b0;
    tick();
    reset = 1'b1;
    m_tready = 1'b1;
    repeat (2) tick();
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_tvalid_post", {31'd0, m_tvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
